// File: rtl/alu_exec_stage.sv
// alu_exec_stage: sequential execute stage around the 8-bit combinational ALU.
// Holds the accumulator (ALU operand A) and the operand register (ALU operand B),
// waits a programmed number of settle cycles, then writes back the ALU result and
// the C/V/N/Z flags. Optional feature macro: DIV_BY_ZERO_TRAP_EN (divide-by-zero
// trap; when undefined a DIV by zero runs through the ALU and div_err stays 0).
module alu_exec_stage #(
  parameter int ARITH_WAIT  = 1,
  parameter int MULDIV_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_operand,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_sub,
  output logic [2:0] alu_op_select,
  input  logic [7:0] alu_result,
  input  logic       alu_cout,
  input  logic       alu_overflow,
  output logic [7:0] acc,
  output logic       flag_c,
  output logic       flag_v,
  output logic       flag_n,
  output logic       flag_z,
  output logic       done,
  output logic       div_err
);

  localparam int CW = $clog2(MULDIV_WAIT + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_LDA = 3'b110;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   wait_load;
  logic [2:0]      op_q;
  logic [7:0]      opnd_q;
  logic [7:0]      acc_q;
  logic            c_q, v_q, n_q, z_q;
  logic            done_q;
  logic [2:0]      alu_sel_q;
  logic            alu_sub_q;
  logic            accept;
  logic            capture;
  logic            div_trap;
  logic            trap_q;

  assign accept  = req_valid && (state_q == S_IDLE);
  assign capture = (state_q == S_EXEC) && (cnt_q == '0);

`ifdef DIV_BY_ZERO_TRAP_EN
  logic div_err_q;
  assign div_trap = (req_op == OP_DIV) && (req_operand == 8'h00);
  assign div_err  = div_err_q;
`else
  assign div_trap = 1'b0;
  assign div_err  = 1'b0;
`endif

  // Settle-cycle count loaded at accept (WAIT-1); LDA/NOP/trapped DIV take one edge
  always_comb begin
    wait_load = '0;
    case (req_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: wait_load = CW'(ARITH_WAIT - 1);
      OP_MUL, OP_DIV:                wait_load = div_trap ? '0 : CW'(MULDIV_WAIT - 1);
      default:                       wait_load = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> EXEC on accept, EXEC -> IDLE on the capture edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)  state_d = S_EXEC;
      S_EXEC:  if (capture) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: ready only while idle; everything else comes straight from registers
  always_comb begin
    req_ready     = (state_q == S_IDLE);
    alu_a         = acc_q;
    alu_b         = opnd_q;
    alu_sub       = alu_sub_q;
    alu_op_select = alu_sel_q;
    acc           = acc_q;
    flag_c        = c_q;
    flag_v        = v_q;
    flag_n        = n_q;
    flag_z        = z_q;
    done          = done_q;
  end

  // Datapath: latch request at accept, count settle cycles, write back on capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= 3'b000;
      opnd_q    <= 8'h00;
      acc_q     <= 8'h00;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      done_q    <= 1'b0;
      alu_sel_q <= 3'b000;
      alu_sub_q <= 1'b0;
      trap_q    <= 1'b0;
`ifdef DIV_BY_ZERO_TRAP_EN
      div_err_q <= 1'b0;
`endif
    end else begin
      done_q <= capture;
      if (accept) begin
        op_q      <= req_op;
        opnd_q    <= req_operand;
        cnt_q     <= wait_load;
        trap_q    <= div_trap;
        // LDA/NOP leave the ALU on op 000; it is ignored for them anyway
        alu_sel_q <= (req_op[2:1] == 2'b11) ? 3'b000 : req_op;
        alu_sub_q <= (req_op == OP_SUB);
`ifdef DIV_BY_ZERO_TRAP_EN
        div_err_q <= 1'b0;
`endif
      end else if ((state_q == S_EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (capture) begin
        if (trap_q) begin
`ifdef DIV_BY_ZERO_TRAP_EN
          div_err_q <= 1'b1;
`endif
        end else begin
          case (op_q)
            OP_LDA: begin
              acc_q <= opnd_q;
              n_q   <= opnd_q[7];
              z_q   <= (opnd_q == 8'h00);
            end
            OP_ADD, OP_SUB: begin
              acc_q <= alu_result;
              c_q   <= alu_cout;
              v_q   <= alu_overflow;
              n_q   <= alu_result[7];
              z_q   <= (alu_result == 8'h00);
            end
            OP_AND, OP_OR, OP_MUL, OP_DIV: begin
              acc_q <= alu_result;
              c_q   <= 1'b0;
              v_q   <= 1'b0;
              n_q   <= alu_result[7];
              z_q   <= (alu_result == 8'h00);
            end
            default: ; // NOP: nothing changes, done still pulses
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: behavioural 8-bit ALU, table-driven vectors,
// scoreboard queue checked on every done pulse, plus reset-abort and div-by-zero
// sequences (expectations follow DIV_BY_ZERO_TRAP_EN if defined).
`timescale 1ns/1ps
module tb_alu_exec_stage;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_LDA = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'b000;
  logic [7:0] req_operand = 8'h00;
  logic [7:0] alu_a, alu_b;
  logic       alu_sub;
  logic [2:0] alu_op_select;
  logic [7:0] alu_result;
  logic       alu_cout, alu_overflow;
  logic [7:0] acc;
  logic       flag_c, flag_v, flag_n, flag_z;
  logic       done, div_err;

  int checks = 0;
  int failures = 0;

  alu_exec_stage dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_operand(req_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_op_select(alu_op_select),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .acc(acc), .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z),
    .done(done), .div_err(div_err)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit ALU (add/sub via invert+carry-in, truncating mul, div0 -> FF)
  logic [8:0] alu_sum;
  logic [7:0] alu_bb;
  always_comb begin
    alu_sum      = 9'd0;
    alu_bb       = 8'h00;
    alu_result   = 8'h00;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op_select)
      3'b000, 3'b001: begin
        alu_bb       = alu_sub ? ~alu_b : alu_b;
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_bb} + {8'd0, alu_sub};
        alu_result   = alu_sum[7:0];
        alu_cout     = alu_sum[8];
        alu_overflow = (alu_a[7] == alu_bb[7]) && (alu_sum[7] != alu_a[7]);
      end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = 8'(alu_a * alu_b);
      3'b101: alu_result = (alu_b == 8'h00) ? 8'hFF : (alu_a / alu_b);
      default: alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] opnd;
    logic [7:0] acc;
    logic       c, v, n, z, de;
    int         lat;
    longint     t;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[14];
  vec_t mon_e;
  int   mon_lat;

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] opnd,
                              input logic [7:0] a, input logic c, input logic v,
                              input logic n, input logic z, input logic de, input int lat);
    vec_t r;
    r.op = op; r.opnd = opnd; r.acc = a;
    r.c = c; r.v = v; r.n = n; r.z = z; r.de = de;
    r.lat = lat; r.t = 0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse pops one expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e   = sb.pop_front();
        mon_lat = int'(($time - mon_e.t) / 10) - 1;
        $display("txn op=%0d opnd=%02h acc=%02h cvnz=%b%b%b%b div_err=%b lat=%0d",
                 mon_e.op, mon_e.opnd, acc, flag_c, flag_v, flag_n, flag_z, div_err, mon_lat);
        chk("result{acc,c,v,n,z,div_err}", {19'd0, acc, flag_c, flag_v, flag_n, flag_z, div_err},
            {19'd0, mon_e.acc, mon_e.c, mon_e.v, mon_e.n, mon_e.z, mon_e.de});
        chk("latency", mon_lat, mon_e.lat);
        chk("ready_with_done", {31'd0, req_ready}, 32'd1);
      end
    end
  end

  // Drive one request; waits (bounded) for ready, pushes expectation at accept
  task automatic send(input vec_t v);
    int   n;
    logic rdy;
    n = 0; rdy = 1'b0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      req_valid   = 1'b1;
      req_op      = v.op;
      req_operand = v.opnd;
      rdy         = req_ready;
      v.t         = $time;
      @(posedge clk);
      n++;
    end
    if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
    else      sb.push_back(v);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_acc"}, {24'd0, acc}, 32'h00);
    chk({nm, "_flags"}, {28'd0, flag_c, flag_v, flag_n, flag_z}, 32'd0);
    chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({nm, "_done_diverr"}, {30'd0, done, div_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_done;

    // Vector table: chained ops, expected acc/flags/latency worked out by hand
    tbl[0]  = mk(OP_LDA, 8'h7F, 8'h7F, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(OP_ADD, 8'h01, 8'h80, 0, 1, 1, 0, 0, 1);
    tbl[2]  = mk(OP_LDA, 8'h0F, 8'h0F, 0, 1, 0, 0, 0, 1);
    tbl[3]  = mk(OP_MUL, 8'h10, 8'hF0, 0, 0, 1, 0, 0, 4);
    tbl[4]  = mk(OP_LDA, 8'hFF, 8'hFF, 0, 0, 1, 0, 0, 1);
    tbl[5]  = mk(OP_SUB, 8'hFF, 8'h00, 1, 0, 0, 1, 0, 1);
    tbl[6]  = mk(OP_AND, 8'h00, 8'h00, 0, 0, 0, 1, 0, 1);
    tbl[7]  = mk(OP_OR,  8'hA5, 8'hA5, 0, 0, 1, 0, 0, 1);
    tbl[8]  = mk(OP_ADD, 8'h5B, 8'h00, 1, 0, 0, 1, 0, 1);
    tbl[9]  = mk(OP_NOP, 8'h33, 8'h00, 1, 0, 0, 1, 0, 1);
    tbl[10] = mk(OP_LDA, 8'h64, 8'h64, 1, 0, 0, 0, 0, 1);
    tbl[11] = mk(OP_DIV, 8'h07, 8'h0E, 0, 0, 0, 0, 0, 4);
    tbl[12] = mk(OP_SUB, 8'h10, 8'hFE, 0, 0, 1, 0, 0, 1);
    tbl[13] = mk(OP_ADD, 8'h80, 8'h7E, 1, 1, 0, 0, 0, 1);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_state("reset");
    chk("reset_alu_sel", {29'd0, alu_op_select}, 32'd0);

    // Table, issued back-to-back (each next request lands in the done cycle)
    for (int i = 0; i < 14; i++) send(tbl[i]);
    drain();

    // Reset pulsed two cycles into a MUL: op aborted, no done
    send(mk(OP_LDA, 8'h0F, 8'h0F, 1, 1, 0, 0, 0, 1));
    drain();
    send(mk(OP_MUL, 8'h10, 8'hF0, 0, 0, 1, 0, 0, 4));
    @(negedge clk);
    chk("mul_alu_ports", {28'd0, alu_sub, alu_op_select}, {28'd0, 1'b0, OP_MUL});
    chk("mul_busy", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk_reset_state("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    chk("abort_acc", {24'd0, acc}, 32'h00);

    // Divide by zero
    send(mk(OP_LDA, 8'h09, 8'h09, 0, 0, 0, 0, 0, 1));
`ifdef DIV_BY_ZERO_TRAP_EN
    send(mk(OP_DIV, 8'h00, 8'h09, 0, 0, 0, 0, 1, 1));
    send(mk(OP_NOP, 8'h00, 8'h09, 0, 0, 0, 0, 0, 1));
`else
    send(mk(OP_DIV, 8'h00, 8'hFF, 0, 0, 1, 0, 0, 4));
    send(mk(OP_NOP, 8'h00, 8'hFF, 0, 0, 1, 0, 0, 1));
`endif
    drain();
    @(negedge clk);
    chk("final_div_err", {31'd0, div_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
